// File: rtl/sram_like_arbiter.sv
// Fixed-priority arbiter merging an instruction and a data SRAM-like master onto one slave port.
// An owner FIFO remembers who issued each accepted request so in-order responses can be steered back.
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    logic [OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;

    logic full;
    logic not_empty;
    logic gnt_data;
    logic gnt_inst;
    logic head_owner;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // full comes from registered count only, so a pop while full frees a slot one cycle later
    assign full      = (count == CNT_FULL);
    assign not_empty = (count != '0);

    assign gnt_data = resetn & data_req & ~full;
    assign gnt_inst = resetn & inst_req & ~data_req & ~full;

    assign head_owner = owner_q[head];
    assign push       = req & addr_ok;
    assign pop        = resetn & data_ok & not_empty;

    assign req          = gnt_data | gnt_inst;
    assign data_addr_ok = gnt_data & addr_ok;
    assign inst_addr_ok = gnt_inst & addr_ok;

    assign wr    = gnt_data ? data_wr    : inst_wr;
    assign size  = gnt_data ? data_size  : inst_size;
    assign addr  = gnt_data ? data_addr  : inst_addr;
    assign wstrb = gnt_data ? data_wstrb : inst_wstrb;
    assign wdata = gnt_data ? data_wdata : inst_wdata;

    // Spurious responses with nothing outstanding are dropped by gating on not_empty
    assign data_data_ok = pop & head_owner;
    assign inst_data_ok = pop & ~head_owner;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                owner_q[tail] <= gnt_data;
                tail          <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (OUTSTANDING=2): priority, routing, full, simultaneous push/pop,
// spurious responses and mid-transaction reset.
module tb_sram_like_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    sram_like_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr, input logic dwr,
                                 input logic aok, input logic dok, input logic [31:0] rdat);
        inst_req = ireq;
        inst_addr = iaddr;
        data_req = dreq;
        data_addr = daddr;
        data_wr = dwr;
        addr_ok = aok;
        data_ok = dok;
        rdata = rdat;
        #2;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wstrb = 4'h0;
        inst_wdata = 32'hAAAA0000;
        data_size  = 2'd0;
        data_wstrb = 4'hF;
        data_wdata = 32'h5555AAAA;

        // Outputs held low in reset despite active inputs
        applyStimulus(1, 32'hBFC00000, 1, 32'h80001000, 1, 1, 1, 32'h0);
        checkOutput("rst_req", req, 0);
        checkOutput("rst_d_aok", data_addr_ok, 0);
        checkOutput("rst_i_aok", inst_addr_ok, 0);
        checkOutput("rst_d_dok", data_data_ok, 0);
        checkOutput("rst_i_dok", inst_data_ok, 0);
        stepClock();
        checkOutput("rst_count", 32'(dut.count), 0);
        resetn = 1'b1;

        // Priority: data wins
        applyStimulus(1, 32'hBFC00000, 1, 32'h80001000, 1, 1, 0, 32'h0);
        checkOutput("pri_req", req, 1);
        checkOutput("pri_addr", addr, 32'h80001000);
        checkOutput("pri_wr", wr, 1);
        checkOutput("pri_wstrb", wstrb, 4'hF);
        checkOutput("pri_wdata", wdata, 32'h5555AAAA);
        checkOutput("pri_size", size, 0);
        checkOutput("pri_d_aok", data_addr_ok, 1);
        checkOutput("pri_i_aok", inst_addr_ok, 0);
        stepClock();
        applyStimulus(1, 32'hBFC00000, 0, 32'h80001000, 1, 1, 0, 32'h0);
        checkOutput("pri2_addr", addr, 32'hBFC00000);
        checkOutput("pri2_wr", wr, 0);
        checkOutput("pri2_size", size, 2);
        checkOutput("pri2_i_aok", inst_addr_ok, 1);
        checkOutput("pri2_d_aok", data_addr_ok, 0);
        stepClock();
        checkOutput("pri_count2", 32'(dut.count), 2);
        // Full: no grant; pop this cycle goes to data (first owner)
        applyStimulus(1, 32'hBFC00004, 0, 32'h0, 0, 1, 1, 32'h33);
        checkOutput("full_req", req, 0);
        checkOutput("full_i_aok", inst_addr_ok, 0);
        checkOutput("full_d_dok", data_data_ok, 1);
        checkOutput("full_i_dok", inst_data_ok, 0);
        checkOutput("full_rdata", data_rdata, 32'h33);
        stepClock();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h44);
        checkOutput("drain_i_dok", inst_data_ok, 1);
        checkOutput("drain_d_dok", data_data_ok, 0);
        stepClock();
        checkOutput("drain_count", 32'(dut.count), 0);

        // Routing: inst then data, responses in order
        applyStimulus(1, 32'hBFC00010, 0, 32'h0, 0, 1, 0, 32'h0);
        stepClock();
        applyStimulus(0, 32'h0, 1, 32'h80002000, 0, 1, 0, 32'h0);
        checkOutput("rt_d_aok", data_addr_ok, 1);
        stepClock();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h11111111);
        checkOutput("rt1_i_dok", inst_data_ok, 1);
        checkOutput("rt1_d_dok", data_data_ok, 0);
        checkOutput("rt1_rdata", inst_rdata, 32'h11111111);
        stepClock();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h22222222);
        checkOutput("rt2_d_dok", data_data_ok, 1);
        checkOutput("rt2_i_dok", inst_data_ok, 0);
        checkOutput("rt2_rdata", data_rdata, 32'h22222222);
        stepClock();
        checkOutput("rt_count", 32'(dut.count), 0);

        // Full then release: pop while full keeps req low until next cycle
        applyStimulus(1, 32'hBFC00020, 0, 32'h0, 0, 1, 0, 32'h0);
        stepClock();
        applyStimulus(1, 32'hBFC00024, 0, 32'h0, 0, 1, 0, 32'h0);
        stepClock();
        applyStimulus(1, 32'hBFC00028, 0, 32'h0, 0, 1, 0, 32'h0);
        checkOutput("f3_req", req, 0);
        stepClock();
        checkOutput("f3_count", 32'(dut.count), 2);
        applyStimulus(1, 32'hBFC00028, 0, 32'h0, 0, 1, 1, 32'h55);
        checkOutput("f4_req", req, 0);
        checkOutput("f4_i_dok", inst_data_ok, 1);
        stepClock();
        applyStimulus(1, 32'hBFC00028, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("f5_req", req, 1);
        checkOutput("f5_i_aok", inst_addr_ok, 0);
        checkOutput("f5_count", 32'(dut.count), 1);

        // Simultaneous push (data) and pop (inst) at count=1
        applyStimulus(0, 32'h0, 1, 32'h80003000, 0, 1, 1, 32'h66);
        checkOutput("sim_i_dok", inst_data_ok, 1);
        checkOutput("sim_d_dok", data_data_ok, 0);
        checkOutput("sim_d_aok", data_addr_ok, 1);
        stepClock();
        checkOutput("sim_count", 32'(dut.count), 1);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h77);
        checkOutput("sim_head_d_dok", data_data_ok, 1);
        checkOutput("sim_head_i_dok", inst_data_ok, 0);
        stepClock();

        // Spurious response at count=0, and a request dropped before addr_ok
        applyStimulus(0, 32'h0, 1, 32'h80004000, 0, 0, 1, 32'h88);
        checkOutput("sp_d_dok", data_data_ok, 0);
        checkOutput("sp_i_dok", inst_data_ok, 0);
        stepClock();
        checkOutput("sp_count", 32'(dut.count), 0);

        // Mid-transaction reset at count=2
        applyStimulus(0, 32'h0, 1, 32'h80005000, 0, 1, 0, 32'h0);
        stepClock();
        applyStimulus(1, 32'hBFC00030, 0, 32'h0, 0, 1, 0, 32'h0);
        stepClock();
        checkOutput("pr_count2", 32'(dut.count), 2);
        resetn = 1'b0;
        applyStimulus(1, 32'hBFC00030, 0, 32'h0, 0, 1, 0, 32'h0);
        checkOutput("pr_count_rst", 32'(dut.count), 0);
        checkOutput("pr_req_rst", req, 0);
        stepClock();
        resetn = 1'b1;
        applyStimulus(1, 32'hBFC00030, 0, 32'h0, 0, 0, 1, 32'h99);
        checkOutput("pr_req_rel", req, 1);
        checkOutput("pr_i_dok", inst_data_ok, 0);
        checkOutput("pr_d_dok", data_data_ok, 0);
        stepClock();
        checkOutput("pr_count_rel", 32'(dut.count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter OUTSTANDING, default 2, meaning maximum accepted-but-unanswered transactions on the shared port; legal values are 1, 2 and 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 inst_req, inst_wr  input  1 each  instruction master request / write flag.
REQ-005 inst_size  input  2  instruction transfer size (0=byte, 1=half, 2=word).
REQ-006 inst_addr, inst_wdata  input  32 each  instruction address / write data.
REQ-007 inst_wstrb  input  4  instruction byte strobes.
REQ-008 inst_addr_ok, inst_data_ok  output  1 each  instruction request accepted / response returned.
REQ-009 inst_rdata  output  32  instruction read data.
REQ-010 data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, data_addr_ok, data_data_ok, data_rdata SHALL have the same widths and directions as their inst_* counterparts and serve the data master.
REQ-011 req, wr  output  1 each  shared-port request / write flag.
REQ-012 size  output  2  shared-port transfer size.
REQ-013 addr, wdata  output  32 each  shared-port address / write data.
REQ-014 wstrb  output  4  shared-port byte strobes.
REQ-015 addr_ok, data_ok  input  1 each  shared-port request accepted / response returned.
REQ-016 rdata  input  32  shared-port read data.

Function
REQ-017 The block SHALL arbitrate two SRAM-like masters onto one SRAM-like slave port and add zero cycles of latency; every grant and response path SHALL be combinational.
REQ-018 Priority SHALL be fixed: gnt_data = data_req & ~full; gnt_inst = inst_req & ~data_req & ~full.
REQ-019 req SHALL equal gnt_data | gnt_inst.
REQ-020 wr, size, addr, wstrb and wdata SHALL come from the data master when gnt_data is set, otherwise from the instruction master.
REQ-021 data_addr_ok SHALL equal gnt_data & addr_ok, and inst_addr_ok SHALL equal gnt_inst & addr_ok; a master that is not granted SHALL never see addr_ok.
REQ-022 An owner FIFO of OUTSTANDING entries, 1 bit per entry (1=data, 0=inst), SHALL be kept with a head pointer, tail pointer and count in the range 0..OUTSTANDING.
REQ-023 Push: when req & addr_ok, the owner bit SHALL be written at the tail, the tail SHALL advance modulo OUTSTANDING, and count SHALL increment.
REQ-024 Pop: when data_ok & (count != 0), the head SHALL advance modulo OUTSTANDING and count SHALL decrement.
REQ-025 A push and a pop in the same cycle SHALL both take effect with count unchanged; this SHALL also hold at count == OUTSTANDING-1 and count == 1.
REQ-026 full SHALL equal (count == OUTSTANDING); while full, req SHALL be 0 and both addr_ok outputs SHALL be 0.
REQ-027 A pop in the same cycle as full SHALL NOT unblock req until the next cycle, so that full is registered-state based.
REQ-028 data_data_ok SHALL equal data_ok & (count != 0) & head_owner, and inst_data_ok SHALL equal data_ok & (count != 0) & ~head_owner.
REQ-029 Write completions SHALL be routed by the same rule as read completions.
REQ-030 inst_rdata and data_rdata SHALL both be driven directly from rdata; only the data_ok strobes SHALL be steered.
REQ-031 data_ok while count == 0 is a slave protocol error: it SHALL be ignored, with no pop, no data_ok to either master, and no counter underflow.
REQ-032 The slave SHALL return responses in request order; the block SHALL NOT reorder responses.
REQ-033 A master dropping req before addr_ok SHALL leave no state behind: nothing is pushed until the handshake completes.

Reset
REQ-034 While resetn = 0: count = 0, head = 0, tail = 0, and all FIFO entries = 0.
REQ-035 While resetn = 0: req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL be 0, regardless of the other inputs.
REQ-036 Reset asserted mid-transaction SHALL discard all outstanding ownership; responses arriving after reset falls SHALL be treated as in REQ-031.

Verification
REQ-037 Scenario (priority): inst_req=1 addr=0xBFC00000, data_req=1 addr=0x80001000 wr=1 wstrb=0xF, addr_ok=1 -> addr=0x80001000, wr=1, data_addr_ok=1, inst_addr_ok=0; next cycle with data_req=0 -> addr=0xBFC00000, inst_addr_ok=1.
REQ-038 Scenario (routing): accept inst then data, then data_ok twice with rdata=0x11111111 then 0x22222222 -> inst_data_ok=1 with 0x11111111, then data_data_ok=1 with 0x22222222.
REQ-039 Scenario (full, OUTSTANDING=2): two accepts with no data_ok -> req=0 on the third cycle even with inst_req=1; one data_ok -> req=1 on the next cycle.
REQ-040 Scenario (simultaneous): count=1 (owner inst); data request accepted in the same cycle as data_ok -> inst_data_ok=1, count stays 1, new head owner = data.
REQ-041 Scenario (spurious/reset): data_ok=1 with count=0 -> both *_data_ok stay 0 and count stays 0; resetn pulsed low at count=2 -> count=0 and req follows REQ-018 on release.
